cart_bus_master: RTL and testbench

Cartridge-bus sequencer that turns single-byte access requests into DMG-timed cartridge bus cycles (a, d, nrd, nwr, ncs) and returns read data. It sits directly upstream of the cartridge mapper and its ROM/SRAM models. Testbenches and the CPU-side bus model drive cartridge traffic through it. Each access occupies exactly one M-cycle of 8 clk phases.

---
 rtl/cart_bus_pkg.sv | 38 +++
 rtl/cart_bus_master.sv | 106 ++++++++++
 tb/tb_cart_bus_master.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cart_bus_pkg.sv
// Shared types and phase-window constants for the cartridge bus sequencer.
// Each bus strobe is active over an inclusive range of M-cycle phases.
package cart_bus_pkg;

   typedef enum logic [3:0] {
      P0   = 4'd0,
      P1   = 4'd1,
      P2   = 4'd2,
      P3   = 4'd3,
      P4   = 4'd4,
      P5   = 4'd5,
      P6   = 4'd6,
      P7   = 4'd7,
      IDLE = 4'd8
   } phase_t;

   localparam logic [2:0] NRD_FIRST    = 3'd0;
   localparam logic [2:0] NRD_LAST     = 3'd6;
   localparam logic [2:0] NCS_FIRST    = 3'd1;
   localparam logic [2:0] NCS_LAST     = 3'd6;
   localparam logic [2:0] NWR_FIRST    = 3'd4;
   localparam logic [2:0] NWR_LAST     = 3'd6;
   localparam logic [2:0] DOE_FIRST    = 3'd2;
   localparam logic [2:0] DOE_LAST     = 3'd7;
   localparam logic [2:0] SAMPLE_PHASE = 3'd6;

   localparam logic [15:0] DEFAULT_CS_LO = 16'hA000;
   localparam logic [15:0] DEFAULT_CS_HI = 16'hFDFF;

   // IDLE encodes above every phase index, so it never falls inside a window.
   function automatic logic in_window(input phase_t ph, input logic [2:0] first,
                                      input logic [2:0] last);
      logic [3:0] v;
      v = ph;
      return (v >= {1'b0, first}) && (v <= {1'b0, last});
   endfunction

endpackage

// File: rtl/cart_bus_master.sv
// Turns single-byte requests into 8-phase DMG cartridge bus cycles.
// Bus pins are registered from the next phase so they change exactly at phase entry.
module cart_bus_master
   import cart_bus_pkg::*;
#(
   parameter logic [15:0] CS_LO = DEFAULT_CS_LO,
   parameter logic [15:0] CS_HI = DEFAULT_CS_HI
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic [15:0] a,
   output logic [7:0]  d_out,
   output logic        d_oe,
   input  logic [7:0]  d_in,
   output logic        nrd,
   output logic        nwr,
   output logic        ncs
);

   phase_t      state;
   phase_t      next_state;
   logic        accept;
   logic [15:0] addr_q;
   logic [7:0]  wdata_q;
   logic        write_q;
   logic [15:0] n_addr;
   logic [7:0]  n_wdata;
   logic        n_write;
   logic        n_sel;

   assign req_ready = (state == IDLE) || (state == P7);

   always_comb begin
      next_state = IDLE;
      accept     = req_valid && req_ready;
      unique case (state)
         IDLE:    next_state = accept ? P0 : IDLE;
         P0:      next_state = P1;
         P1:      next_state = P2;
         P2:      next_state = P3;
         P3:      next_state = P4;
         P4:      next_state = P5;
         P5:      next_state = P6;
         P6:      next_state = P7;
         P7:      next_state = accept ? P0 : IDLE;
         default: next_state = IDLE;
      endcase
      // The access seen during the next phase: fresh request on accept, else the latched one.
      n_addr  = accept ? req_addr  : addr_q;
      n_wdata = accept ? req_wdata : wdata_q;
      n_write = accept ? req_write : write_q;
      n_sel   = (n_addr >= CS_LO) && (n_addr <= CS_HI);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state   <= IDLE;
         addr_q  <= 16'h0000;
         wdata_q <= 8'h00;
         write_q <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            write_q <= req_write;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         a         <= 16'h0000;
         d_out     <= 8'h00;
         d_oe      <= 1'b0;
         nrd       <= 1'b1;
         nwr       <= 1'b1;
         ncs       <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 8'h00;
      end else begin
         if (next_state != IDLE) begin
            a <= n_addr;
         end
         nrd  <= !(!n_write && in_window(next_state, NRD_FIRST, NRD_LAST));
         nwr  <= !( n_write && in_window(next_state, NWR_FIRST, NWR_LAST));
         ncs  <= !( n_sel   && in_window(next_state, NCS_FIRST, NCS_LAST));
         d_oe <=    n_write && in_window(next_state, DOE_FIRST, DOE_LAST);
         if (n_write && in_window(next_state, DOE_FIRST, DOE_LAST)) begin
            d_out <= n_wdata;
         end
         rsp_valid <= (next_state == P7);
         if (!write_q && in_window(state, SAMPLE_PHASE, SAMPLE_PHASE)) begin
            rsp_rdata <= d_in;
         end
      end
   end

endmodule

// File: tb/tb_cart_bus_master.sv
// Directed bench for cart_bus_master: checks every phase of each access against
// hand-derived strobe windows, plus boundaries, back-to-back, async reset and capture timing.
module tb_cart_bus_master;

   logic        clk;
   logic        nrst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic [15:0] a;
   logic [7:0]  d_out;
   logic        d_oe;
   logic [7:0]  d_in;
   logic        nrd;
   logic        nwr;
   logic        ncs;

   int          checks;
   int          failures;
   logic [7:0]  exp_rdata;
   logic [7:0]  exp_dout;

   cart_bus_master dut (
      .clk       (clk),
      .nrst      (nrst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .a         (a),
      .d_out     (d_out),
      .d_oe      (d_oe),
      .d_in      (d_in),
      .nrd       (nrd),
      .nwr       (nwr),
      .ncs       (ncs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [7:0] wd);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
   endtask

   // Runs one access whose request is already presented; leaves the bench at the P7 negedge.
   task automatic runAccess(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                            input logic sel, input logic [7:0] din, input logic hold,
                            input logic glitch);
      @(posedge clk);
      for (int p = 0; p < 8; p++) begin
         @(negedge clk);
         if (p == 0) begin
            req_addr  = 16'hBEEF;
            req_wdata = 8'hEE;
            req_write = ~wr;
            if (!hold) req_valid = 1'b0;
         end
         if (wr && p >= 2) exp_dout = wd;
         if (!wr && p == 7) exp_rdata = din;
         checkOutput($sformatf("a_p%0d", p), a, addr);
         checkOutput($sformatf("nrd_p%0d", p), {15'd0, nrd}, (!wr && p <= 6) ? 16'd0 : 16'd1);
         checkOutput($sformatf("nwr_p%0d", p), {15'd0, nwr}, (wr && p >= 4 && p <= 6) ? 16'd0 : 16'd1);
         checkOutput($sformatf("ncs_p%0d", p), {15'd0, ncs}, (sel && p >= 1 && p <= 6) ? 16'd0 : 16'd1);
         checkOutput($sformatf("d_oe_p%0d", p), {15'd0, d_oe}, (wr && p >= 2) ? 16'd1 : 16'd0);
         checkOutput($sformatf("d_out_p%0d", p), {8'd0, d_out}, {8'd0, exp_dout});
         checkOutput($sformatf("rsp_valid_p%0d", p), {15'd0, rsp_valid}, (p == 7) ? 16'd1 : 16'd0);
         checkOutput($sformatf("req_ready_p%0d", p), {15'd0, req_ready}, (p == 7) ? 16'd1 : 16'd0);
         checkOutput($sformatf("rsp_rdata_p%0d", p), {8'd0, rsp_rdata}, {8'd0, exp_rdata});
         if (!wr && p == 6) begin
            d_in = din;
            if (glitch) begin
               @(posedge clk);
               #1 d_in = ~din;
            end
         end
      end
   endtask

   task automatic checkIdle(input logic [15:0] addr);
      @(negedge clk);
      checkOutput("idle_a", a, addr);
      checkOutput("idle_nrd", {15'd0, nrd}, 16'd1);
      checkOutput("idle_nwr", {15'd0, nwr}, 16'd1);
      checkOutput("idle_ncs", {15'd0, ncs}, 16'd1);
      checkOutput("idle_d_oe", {15'd0, d_oe}, 16'd0);
      checkOutput("idle_d_out", {8'd0, d_out}, {8'd0, exp_dout});
      checkOutput("idle_rsp_valid", {15'd0, rsp_valid}, 16'd0);
      checkOutput("idle_req_ready", {15'd0, req_ready}, 16'd1);
      checkOutput("idle_rsp_rdata", {8'd0, rsp_rdata}, {8'd0, exp_rdata});
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_a"}, a, 16'h0000);
      checkOutput({tag, "_d_out"}, {8'd0, d_out}, 16'h0000);
      checkOutput({tag, "_d_oe"}, {15'd0, d_oe}, 16'd0);
      checkOutput({tag, "_nrd"}, {15'd0, nrd}, 16'd1);
      checkOutput({tag, "_nwr"}, {15'd0, nwr}, 16'd1);
      checkOutput({tag, "_ncs"}, {15'd0, ncs}, 16'd1);
      checkOutput({tag, "_rsp_valid"}, {15'd0, rsp_valid}, 16'd0);
      checkOutput({tag, "_rsp_rdata"}, {8'd0, rsp_rdata}, 16'h0000);
      checkOutput({tag, "_req_ready"}, {15'd0, req_ready}, 16'd1);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      exp_rdata = 8'h00;
      exp_dout  = 8'h00;
      nrst      = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 16'h0000;
      req_wdata = 8'h00;
      d_in      = 8'h00;
      #1 nrst = 1'b0;
      #1 checkResetValues("por");
      @(negedge clk);
      nrst = 1'b1;

      $display("[TB] write 2000 <- 05, read 4123");
      applyStimulus(1'b1, 16'h2000, 8'h05);
      runAccess(1'b1, 16'h2000, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0);
      checkIdle(16'h2000);
      applyStimulus(1'b0, 16'h4123, 8'h00);
      runAccess(1'b0, 16'h4123, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0);
      checkIdle(16'h4123);

      $display("[TB] chip-select boundaries");
      applyStimulus(1'b1, 16'hA000, 8'h3C);
      runAccess(1'b1, 16'hA000, 8'h3C, 1'b1, 8'h00, 1'b0, 1'b0);
      checkIdle(16'hA000);
      applyStimulus(1'b0, 16'h9FFF, 8'h00);
      runAccess(1'b0, 16'h9FFF, 8'h00, 1'b0, 8'h81, 1'b0, 1'b0);
      checkIdle(16'h9FFF);
      applyStimulus(1'b0, 16'hFDFF, 8'h00);
      runAccess(1'b0, 16'hFDFF, 8'h00, 1'b1, 8'h82, 1'b0, 1'b0);
      checkIdle(16'hFDFF);
      applyStimulus(1'b0, 16'hFE00, 8'h00);
      runAccess(1'b0, 16'hFE00, 8'h00, 1'b0, 8'h83, 1'b0, 1'b0);
      checkIdle(16'hFE00);
      applyStimulus(1'b0, 16'hFFFF, 8'h00);
      runAccess(1'b0, 16'hFFFF, 8'h00, 1'b0, 8'h84, 1'b0, 1'b0);
      checkIdle(16'hFFFF);

      $display("[TB] four back-to-back reads");
      applyStimulus(1'b0, 16'h4000, 8'h00);
      runAccess(1'b0, 16'h4000, 8'h00, 1'b0, 8'h11, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h4001, 8'h00);
      runAccess(1'b0, 16'h4001, 8'h00, 1'b0, 8'h22, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'hB002, 8'h00);
      runAccess(1'b0, 16'hB002, 8'h00, 1'b1, 8'h33, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h4003, 8'h00);
      runAccess(1'b0, 16'h4003, 8'h00, 1'b0, 8'h44, 1'b0, 1'b0);
      checkIdle(16'h4003);

      $display("[TB] async reset during P5 of a write");
      applyStimulus(1'b1, 16'h0000, 8'h0A);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("pre_reset_nwr_p5", {15'd0, nwr}, 16'd0);
      checkOutput("pre_reset_d_oe_p5", {15'd0, d_oe}, 16'd1);
      #1 nrst = 1'b0;
      #1 checkResetValues("mid");
      exp_rdata = 8'h00;
      exp_dout  = 8'h00;
      repeat (3) begin
         @(negedge clk);
         checkOutput("in_reset_rsp_valid", {15'd0, rsp_valid}, 16'd0);
         checkOutput("in_reset_nwr", {15'd0, nwr}, 16'd1);
      end
      nrst = 1'b1;
      applyStimulus(1'b0, 16'h1234, 8'h00);
      runAccess(1'b0, 16'h1234, 8'h00, 1'b0, 8'h77, 1'b0, 1'b0);
      checkIdle(16'h1234);

      $display("[TB] capture timing and hold across a write");
      applyStimulus(1'b0, 16'h5555, 8'h00);
      runAccess(1'b0, 16'h5555, 8'h00, 1'b0, 8'hC3, 1'b0, 1'b1);
      checkIdle(16'h5555);
      applyStimulus(1'b1, 16'h2001, 8'h99);
      runAccess(1'b1, 16'h2001, 8'h99, 1'b0, 8'h00, 1'b0, 1'b0);
      checkIdle(16'h2001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
